// File: rtl/xh_cdb_pkg.sv
// Shared definitions for the xh_cdb channel endpoints: link states,
// credit-return opcode, credit counter sizing and default flit widths.
package xh_cdb_pkg;

    typedef enum logic [1:0] {
        STOP  = 2'd0,
        ACT   = 2'd1,
        RUN   = 2'd2,
        DEACT = 2'd3
    } link_state_e;

    // Opcode carried by a flit that only hands a credit back.
    localparam int LCRD_OPC = 0;

    // Link-level credit limit; also bounds the receive buffer depth.
    localparam int CRD_MAX = 15;
    localparam int CRD_W   = 4;

    // Default flit widths per channel type.
    localparam int REQ_FLIT_W = 127;
    localparam int RSP_FLIT_W = 55;
    localparam int SNP_FLIT_W = 88;
    localparam int DAT_FLIT_W = 392;

endpackage

// File: rtl/xh_cdb_fifo.sv
// Circular receive buffer with a registered head. An entry written at one
// edge becomes visible on valid/head after the following edge; popping
// happens on valid & pop_ready. count covers every entry held, including
// the one shown on head.
module xh_cdb_fifo
    import xh_cdb_pkg::*;
#(
    parameter int FLIT_W = DAT_FLIT_W,
    parameter int DEPTH  = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  logic [FLIT_W-1:0] push_data,
    input  logic              pop_ready,
    output logic              valid,
    output logic [FLIT_W-1:0] head,
    output logic [CRD_W-1:0]  count
);

    localparam int              PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W-1:0] LAST = PTR_W'(DEPTH - 1);

    logic [FLIT_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  rd_ptr_adv;
    logic [CRD_W-1:0]  count_adv;
    logic              pop;

    // Pointers wrap explicitly so non-power-of-two depths work.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == LAST) ? '0 : p + PTR_W'(1);
    endfunction

    // Head position and occupancy once this cycle's pop has been applied.
    always_comb begin
        pop        = valid && pop_ready;
        rd_ptr_adv = pop ? ptr_inc(rd_ptr) : rd_ptr;
        count_adv  = count - CRD_W'(pop);
    end

    // Payload storage; carries no reset.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers, occupancy and the registered head view.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            valid  <= 1'b0;
            head   <= '0;
        end else begin
            if (push) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            rd_ptr <= rd_ptr_adv;
            count  <= count_adv + CRD_W'(push);
            // Only entries already stored before this edge are presented.
            valid  <= (count_adv != '0);
            if (count_adv != '0) begin
                head <= mem[rd_ptr_adv];
            end
        end
    end

endmodule

// File: rtl/xh_cdb_chan_rx.sv
// Receive endpoint for one credited xh_cdb channel: link activation
// handshake, L-credit issue and consumption, protocol error flag and a
// buffered ready/valid output toward the device core. DEPTH must lie in
// 2..15 so that it fits the link credit limit.
module xh_cdb_chan_rx
    import xh_cdb_pkg::*;
#(
    parameter int FLIT_W = DAT_FLIT_W,
    parameter int DEPTH  = 8,
    parameter int OPC_W  = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rx_linkactivereq,
    output logic              rx_linkactiveack,
    input  logic              rx_flitv,
    input  logic [FLIT_W-1:0] rx_flit,
    output logic              rx_lcrdv,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [FLIT_W-1:0] out_flit,
    output logic              crd_err,
    output logic              link_idle
);

    localparam logic [CRD_W:0] DEPTH_S = (CRD_W + 1)'(DEPTH);

    link_state_e      state;
    link_state_e      state_nxt;
    logic [CRD_W-1:0] crd_out;
    logic [CRD_W-1:0] fifo_count;
    logic             crd_room;
    logic             issue;
    logic             flit_bad;
    logic             flit_ok;
    logic             push;

    // Credit issue and flit classification from registered state.
    always_comb begin
        crd_room = ({1'b0, crd_out} + {1'b0, fifo_count}) < DEPTH_S;
        issue    = (state == RUN) && rx_linkactivereq && crd_room;
        flit_bad = rx_flitv && ((state == STOP) || (crd_out == '0));
        flit_ok  = rx_flitv && !flit_bad;
        push     = flit_ok && (rx_flit[OPC_W-1:0] != OPC_W'(LCRD_OPC));
    end

    // Link activation next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            STOP: begin
                if (rx_linkactivereq) state_nxt = ACT;
            end
            ACT: begin
                if (!rx_linkactivereq)     state_nxt = DEACT;
                else if (rx_linkactiveack) state_nxt = RUN;
            end
            RUN: begin
                if (!rx_linkactivereq) state_nxt = DEACT;
            end
            DEACT: begin
                // Requests are ignored until every granted credit is back.
                if (crd_out == '0) state_nxt = STOP;
            end
            default: state_nxt = STOP;
        endcase
    end

    // Link state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= STOP;
        end else begin
            state <= state_nxt;
        end
    end

    // Acknowledge, credit pulse, outstanding-credit count and sticky error.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_linkactiveack <= 1'b0;
            rx_lcrdv         <= 1'b0;
            crd_out          <= '0;
            crd_err          <= 1'b0;
        end else begin
            // High in every cycle the link is out of STOP.
            rx_linkactiveack <= (state_nxt != STOP);
            rx_lcrdv         <= issue;
            crd_out          <= crd_out + CRD_W'(issue) - CRD_W'(flit_ok);
            if (flit_bad) begin
                crd_err <= 1'b1;
            end
        end
    end

    xh_cdb_fifo #(
        .FLIT_W (FLIT_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data (rx_flit),
        .pop_ready (out_ready),
        .valid     (out_valid),
        .head      (out_flit),
        .count     (fifo_count)
    );

    assign link_idle = (state == STOP) && (fifo_count == '0);

    // Granted credits plus held flits never exceed the buffer.
    a_no_overflow: assert property (@(posedge clk) disable iff (reset)
        ({1'b0, crd_out} + {1'b0, fifo_count}) <= DEPTH_S);

    // A push never lands on a full buffer.
    a_push_room: assert property (@(posedge clk) disable iff (reset)
        push |-> ({1'b0, fifo_count} < DEPTH_S));

endmodule

// File: tb/tb_xh_cdb_chan_rx.sv
// Directed bench for xh_cdb_chan_rx with a queue-based reference model
// checked every cycle, plus literal expectations for each scenario.
module tb_xh_cdb_chan_rx;

    localparam int FLIT_W = 392;
    localparam int DEPTH  = 8;
    localparam int OPC_W  = 4;
    localparam int M_STOP = 0;
    localparam int M_ACT  = 1;
    localparam int M_RUN  = 2;
    localparam int M_DEACT = 3;

    logic              clk = 1'b0;
    logic              reset;
    logic              rx_linkactivereq;
    logic              rx_linkactiveack;
    logic              rx_flitv;
    logic [FLIT_W-1:0] rx_flit;
    logic              rx_lcrdv;
    logic              out_valid;
    logic              out_ready;
    logic [FLIT_W-1:0] out_flit;
    logic              crd_err;
    logic              link_idle;

    xh_cdb_chan_rx #(
        .FLIT_W (FLIT_W),
        .DEPTH  (DEPTH),
        .OPC_W  (OPC_W)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .rx_linkactivereq (rx_linkactivereq),
        .rx_linkactiveack (rx_linkactiveack),
        .rx_flitv         (rx_flitv),
        .rx_flit          (rx_flit),
        .rx_lcrdv         (rx_lcrdv),
        .out_valid        (out_valid),
        .out_ready        (out_ready),
        .out_flit         (out_flit),
        .crd_err          (crd_err),
        .link_idle        (link_idle)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int tx_crd = 0;
    int n_pulse = 0;
    int n_deliv = 0;
    int sent = 0;
    logic last_lcrdv = 1'b0;
    logic [11:0] pat;
    logic [FLIT_W-1:0] sentq[$];

    // Reference model state
    int m_st = M_STOP;
    int m_crd = 0;
    bit m_lcrdv = 0;
    bit m_err = 0;
    bit m_valid = 0;
    logic [FLIT_W-1:0] m_head = '0;
    logic [FLIT_W-1:0] m_q[$];

    task automatic chk1(input string nm, input logic act, input logic exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0b want %0b at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chki(input string nm, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d want %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chkf(input string nm, input logic [FLIT_W-1:0] act, input logic [FLIT_W-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    function automatic logic [FLIT_W-1:0] rnd_flit();
        logic [415:0] t;
        for (int w = 0; w < 13; w++) t[w*32 +: 32] = $urandom;
        return t[FLIT_W-1:0];
    endfunction

    // One clock cycle; legal flits use a transmitter credit.
    task automatic cyc(input bit v, input logic [3:0] opc, input bit legal);
        logic [FLIT_W-1:0] f;
        f = rnd_flit();
        f[OPC_W-1:0] = opc;
        rx_flitv = v;
        rx_flit  = f;
        if (v && legal) begin
            tx_crd--;
            if (opc != 4'd0) sentq.push_back(f);
        end
        @(posedge clk);
        #1;
        rx_flitv   = 1'b0;
        last_lcrdv = rx_lcrdv;
        if (rx_lcrdv) begin
            tx_crd++;
            n_pulse++;
        end
    endtask

    // Reference model: link phase, credits and buffer as a queue.
    always @(posedge clk or posedge reset) begin
        int cnt;
        int st_n;
        bit iss;
        bit bad;
        bit take;
        bit pop;
        if (reset) begin
            m_st = M_STOP; m_crd = 0; m_lcrdv = 0; m_err = 0;
            m_valid = 0; m_head = '0; m_q.delete();
        end else begin
            cnt  = m_q.size();
            iss  = (m_st == M_RUN) && rx_linkactivereq && (m_crd + cnt < DEPTH);
            bad  = rx_flitv && (m_st == M_STOP || m_crd == 0);
            take = rx_flitv && !bad;
            pop  = m_valid && out_ready;
            st_n = m_st;
            case (m_st)
                M_STOP:  if (rx_linkactivereq) st_n = M_ACT;
                M_ACT:   st_n = rx_linkactivereq ? M_RUN : M_DEACT;
                M_RUN:   if (!rx_linkactivereq) st_n = M_DEACT;
                default: if (m_crd == 0) st_n = M_STOP;
            endcase
            if (pop) void'(m_q.pop_front());
            m_valid = (m_q.size() != 0);
            if (m_valid) m_head = m_q[0];
            if (take && rx_flit[OPC_W-1:0] != '0) m_q.push_back(rx_flit);
            m_crd   = m_crd + int'(iss) - int'(take);
            m_lcrdv = iss;
            if (bad) m_err = 1;
            m_st = st_n;
        end
    end

    // Every-cycle comparison against the model plus in-order scoreboard.
    always @(negedge clk) begin
        if (!reset) begin
            chk1("ack", rx_linkactiveack, m_st != M_STOP);
            chk1("lcrdv", rx_lcrdv, m_lcrdv);
            chk1("out_valid", out_valid, m_valid);
            chk1("crd_err", crd_err, m_err);
            chk1("link_idle", link_idle, (m_st == M_STOP) && (m_q.size() == 0));
            if (m_valid) chkf("out_flit", out_flit, m_head);
            if (out_valid && out_ready) begin
                n_deliv++;
                if (sentq.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL order: delivered %0h, want nothing", out_flit);
                end else begin
                    chkf("order", out_flit, sentq.pop_front());
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time exceeded");
        $fatal(1);
    end

    initial begin
        reset = 1'b1;
        rx_linkactivereq = 1'b0;
        rx_flitv = 1'b0;
        rx_flit = '0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk1("rst_ack", rx_linkactiveack, 1'b0);
        chk1("rst_lcrdv", rx_lcrdv, 1'b0);
        chk1("rst_valid", out_valid, 1'b0);
        chkf("rst_flit", out_flit, '0);
        chk1("rst_err", crd_err, 1'b0);
        chk1("rst_idle", link_idle, 1'b1);
        reset = 1'b0;

        // Flit while in STOP
        cyc(1, 4'd5, 0);
        chk1("stop_err", crd_err, 1'b1);
        cyc(0, 4'd0, 0);
        cyc(0, 4'd0, 0);
        chk1("stop_err_sticky", crd_err, 1'b1);
        chk1("stop_no_enq", out_valid, 1'b0);
        reset = 1'b1;
        #1;
        chk1("rst2_err", crd_err, 1'b0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        tx_crd = 0;

        // Bring-up
        rx_linkactivereq = 1'b1;
        for (int i = 0; i < 12; i++) begin
            cyc(0, 4'd0, 0);
            pat[i] = last_lcrdv;
            if (i == 0) chk1("bringup_ack", rx_linkactiveack, 1'b1);
        end
        chki("bringup_pattern", int'(pat), 'h3FC);
        chki("bringup_credits", tx_crd, 8);

        // Throughput
        out_ready = 1'b1;
        sent = 0;
        n_deliv = 0;
        for (int c = 0; c < 3000 && sent < 100; c++) begin
            if (tx_crd > 0) begin
                cyc(1, 4'((sent % 15) + 1), 1);
                sent++;
            end else begin
                cyc(0, 4'd0, 0);
            end
        end
        repeat (20) cyc(0, 4'd0, 0);
        chki("tput_sent", sent, 100);
        chki("tput_delivered", n_deliv, 100);
        chki("tput_credits", tx_crd, 8);

        // Backpressure
        out_ready = 1'b0;
        for (int i = 0; i < 8; i++) cyc(1, 4'd7, 1);
        n_pulse = 0;
        repeat (5) cyc(0, 4'd0, 0);
        chki("bp_no_credit", n_pulse, 0);
        chk1("bp_valid", out_valid, 1'b1);
        cyc(1, 4'd3, 0);
        chk1("zero_crd_err", crd_err, 1'b1);
        n_pulse = 0;
        out_ready = 1'b1;
        cyc(0, 4'd0, 0);
        out_ready = 1'b0;
        repeat (3) cyc(0, 4'd0, 0);
        chki("bp_one_credit", n_pulse, 1);
        chki("bp_tx_crd", tx_crd, 1);

        // Deactivate with three credits outstanding
        out_ready = 1'b1;
        repeat (20) cyc(0, 4'd0, 0);
        chki("refill_credits", tx_crd, 8);
        out_ready = 1'b0;
        n_deliv = 0;
        for (int i = 0; i < 5; i++) cyc(1, 4'd9, 1);
        chki("deact_tx_crd", tx_crd, 3);
        rx_linkactivereq = 1'b0;
        cyc(0, 4'd0, 0);
        chk1("deact_ack_held", rx_linkactiveack, 1'b1);
        for (int i = 0; i < 3; i++) cyc(1, 4'd0, 1);
        chk1("deact_ack_still", rx_linkactiveack, 1'b1);
        cyc(0, 4'd0, 0);
        chk1("stop_ack_low", rx_linkactiveack, 1'b0);
        chk1("stop_not_idle", link_idle, 1'b0);
        out_ready = 1'b1;
        repeat (10) cyc(0, 4'd0, 0);
        chki("deact_delivered", n_deliv, 5);
        chk1("stop_idle", link_idle, 1'b1);
        chk1("err_still_sticky", crd_err, 1'b1);

        // Reset mid-run
        rx_linkactivereq = 1'b1;
        repeat (14) cyc(0, 4'd0, 0);
        chki("react_credits", tx_crd, 8);
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) cyc(1, 4'd2, 1);
        #2;
        reset = 1'b1;
        #1;
        chk1("arst_ack", rx_linkactiveack, 1'b0);
        chk1("arst_lcrdv", rx_lcrdv, 1'b0);
        chk1("arst_valid", out_valid, 1'b0);
        chkf("arst_flit", out_flit, '0);
        chk1("arst_err", crd_err, 1'b0);
        chk1("arst_idle", link_idle, 1'b1);
        @(posedge clk);
        #1;
        reset = 1'b0;
        tx_crd = 0;
        sentq.delete();
        n_pulse = 0;
        repeat (14) cyc(0, 4'd0, 0);
        chki("fresh_credits", n_pulse, 8);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
